// File: rtl/rom_arb_pkg.sv
// Shared types and default sizes for the two-port ROM arbiter.
// Optional feature macro used by rom_arbiter: ROM_ARB_FIXED_PRIO_EN.
package rom_arb_pkg;

    localparam int DEF_ADDR_W  = 18;
    localparam int DEF_DATA_W  = 24;
    localparam int DEF_LATENCY = 2;

    typedef logic port_id_t;

    localparam port_id_t PORT0 = 1'b0;
    localparam port_id_t PORT1 = 1'b1;

    typedef struct packed {
        logic     valid;
        port_id_t id;
    } tag_t;

    localparam tag_t TAG_IDLE = '{valid: 1'b0, id: PORT0};

    // Round-robin choice under contention: the port that did not win last time.
    function automatic port_id_t rr_pick(input port_id_t last_grant);
        return ~last_grant;
    endfunction

endpackage

// File: rtl/rom_arb_tag_pipe.sv
// Shift register of {valid, id} tags that follows each ROM read until its
// data appears on the ROM output; cleared synchronously.
module rom_arb_tag_pipe
    import rom_arb_pkg::*;
#(
    parameter int STAGES = DEF_LATENCY + 1
) (
    input  logic clk,
    input  logic srst,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stage_reg  [STAGES];
    tag_t stage_next [STAGES];

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : gen_stage
            if (gi == 0) begin : gen_head
                assign stage_next[gi] = tag_in;
            end else begin : gen_body
                assign stage_next[gi] = stage_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_reg[i] <= TAG_IDLE;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                stage_reg[i] <= stage_next[i];
            end
        end
    end

    assign tag_out = stage_reg[STAGES-1];

endmodule

// File: rtl/rom_arbiter.sv
// Two-requester arbiter in front of one synchronous-read ROM; routes each
// word back to its issuer. Define ROM_ARB_FIXED_PRIO_EN for fixed port-0 priority.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              ack0,
    output logic              ack1,
    output logic              rsp_valid0,
    output logic              rsp_valid1,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    logic [ADDR_W-1:0] rom_addr_reg;
    port_id_t          last_grant_reg;

    logic              grant_valid;
    port_id_t          grant_id;
    logic [ADDR_W-1:0] grant_addr;
    tag_t              tag_in;
    tag_t              tag_out;

    always_comb begin
        grant_valid = 1'b0;
        grant_id    = PORT0;
        if (req0 && req1) begin
            grant_valid = 1'b1;
`ifdef ROM_ARB_FIXED_PRIO_EN
            grant_id    = PORT0;
`else
            grant_id    = rr_pick(last_grant_reg);
`endif
        end else if (req0) begin
            grant_valid = 1'b1;
            grant_id    = PORT0;
        end else if (req1) begin
            grant_valid = 1'b1;
            grant_id    = PORT1;
        end
    end

    assign grant_addr = (grant_id == PORT1) ? addr1 : addr0;
    assign ack0       = grant_valid && (grant_id == PORT0);
    assign ack1       = grant_valid && (grant_id == PORT1);

    // last_grant resets to port 1 so port 0 wins the first contention.
    always_ff @(posedge clock) begin
        if (reset) begin
            rom_addr_reg   <= '0;
            last_grant_reg <= PORT1;
        end else if (grant_valid) begin
            rom_addr_reg   <= grant_addr;
            last_grant_reg <= grant_id;
        end
    end

    assign tag_in = '{valid: grant_valid, id: grant_id};

    rom_arb_tag_pipe #(
        .STAGES (LATENCY + 1)
    ) u_tag_pipe (
        .clk     (clock),
        .srst    (reset),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // Masked by reset so a word due in a reset cycle is never delivered.
    assign rsp_valid0 = tag_out.valid && (tag_out.id == PORT0) && !reset;
    assign rsp_valid1 = tag_out.valid && (tag_out.id == PORT1) && !reset;
    assign rsp_data   = rom_data;
    assign rom_addr   = rom_addr_reg;

endmodule

// File: tb/tb_rom_arbiter.sv
// Randomized and directed bench for rom_arbiter against a queue-based model
// of grants and expected responses; honours ROM_ARB_FIXED_PRIO_EN.
module tb_rom_arbiter;
    import rom_arb_pkg::*;

    localparam int AW  = DEF_ADDR_W;
    localparam int DW  = DEF_DATA_W;
    localparam int LAT = DEF_LATENCY;
`ifdef ROM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          req0, req1;
    logic [AW-1:0] addr0, addr1;
    logic          ack0, ack1;
    logic          rsp_valid0, rsp_valid1;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;

    always #5 clock = ~clock;

    rom_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .LATENCY (LAT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req0       (req0),
        .addr0      (addr0),
        .req1       (req1),
        .addr1      (addr1),
        .ack0       (ack0),
        .ack1       (ack1),
        .rsp_valid0 (rsp_valid0),
        .rsp_valid1 (rsp_valid1),
        .rsp_data   (rsp_data),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data)
    );

    // ROM contents: a fixed scramble of the address.
    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        logic [31:0] x;
        x = {{(32-AW){1'b0}}, a};
        x = (x * 32'h0001_9E37) ^ 32'h00A5_C3F1 ^ (x << 5);
        return x[DW-1:0];
    endfunction

    // Synchronous-read ROM with LAT cycles from rom_addr to rom_data.
    logic [DW-1:0] rom_pipe [LAT];
    always @(posedge clock) begin
        rom_pipe[0] <= rom_word(rom_addr);
        for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_data = rom_pipe[LAT-1];

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          exp_q[$];
    int            cyc;
    int            mdl_last;
    logic [AW-1:0] mdl_rom_addr;
    logic          m_ack0, m_ack1;
    int            vectors;
    int            miscompares;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
    task automatic step(input logic r0, input logic [AW-1:0] a0,
                        input logic r1, input logic [AW-1:0] a1, input logic rst);
        logic e0, e1;
        exp_t e;
        req0 = r0; addr0 = a0; req1 = r1; addr1 = a1; reset = rst;
        @(negedge clock);
        m_ack0 = 1'b0;
        m_ack1 = 1'b0;
        if (r0 && r1) begin
            if (FIXED || mdl_last == 1) m_ack0 = 1'b1;
            else                        m_ack1 = 1'b1;
        end else begin
            m_ack0 = r0;
            m_ack1 = r1;
        end
        chk("ack0", ack0, m_ack0);
        chk("ack1", ack1, m_ack1);
        chk("rom_addr", rom_addr, mdl_rom_addr);
        e0 = 1'b0;
        e1 = 1'b0;
        if (!rst && exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            if (e.id == 0) e0 = 1'b1; else e1 = 1'b1;
            chk("rsp_data", rsp_data, e.data);
            $display("cyc=%0d rsp id=%0d data=%h", cyc, e.id, rsp_data);
        end
        chk("rsp_valid0", rsp_valid0, e0);
        chk("rsp_valid1", rsp_valid1, e1);
        if (rst) begin
            exp_q.delete();
            mdl_last     = 1;
            mdl_rom_addr = '0;
        end else if (m_ack0 || m_ack1) begin
            e.id   = m_ack1 ? 1 : 0;
            e.data = rom_word(m_ack1 ? a1 : a0);
            e.due  = cyc + 1 + LAT;
            exp_q.push_back(e);
            mdl_last     = e.id;
            mdl_rom_addr = m_ack1 ? a1 : a0;
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    initial begin
        logic [AW-1:0] sa;
        logic          rr0, rr1;
        logic [AW-1:0] ra0, ra1;
        vectors = 0; miscompares = 0;
        req0 = 0; req1 = 0; addr0 = '0; addr1 = '0; reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        cyc = 0; mdl_last = 1; mdl_rom_addr = '0;

        // Reset state, then single request on port 0.
        step(0, '0, 0, '0, 1);
        step(1, 18'h00010, 0, '0, 0);
        repeat (5) step(0, '0, 0, '0, 0);

        // Contention straight after reset.
        step(0, '0, 0, '0, 1);
        repeat (4) step(1, 18'h00100, 1, 18'h00200, 0);
        repeat (5) step(0, '0, 0, '0, 0);

        // Streaming on port 1 up to the top of the address space.
        sa = 18'h3FFF8;
        for (int i = 0; i < 8; i++) begin
            step(0, '0, 1, sa, 0);
            if (m_ack1) sa = sa + 1'b1;
        end
        repeat (5) step(0, '0, 0, '0, 0);

        // Reset while a read is in flight.
        step(1, 18'h00055, 0, '0, 0);
        step(0, '0, 0, '0, 1);
        repeat (5) step(0, '0, 0, '0, 0);

        // Held contention, then port 0 drops out.
        repeat (4) step(1, 18'h01234, 1, 18'h04321, 0);
        step(0, '0, 1, 18'h04321, 0);
        repeat (5) step(0, '0, 0, '0, 0);

        // Random traffic with occasional resets.
        rr0 = 0; rr1 = 0; ra0 = '0; ra1 = '0;
        for (int i = 0; i < 300; i++) begin
            step(rr0, ra0, rr1, ra1, ($urandom_range(0, 49) == 0));
            if (m_ack0 || !rr0) begin
                rr0 = $urandom_range(0, 2) != 0;
                ra0 = AW'($urandom);
            end
            if (m_ack1 || !rr1) begin
                rr1 = $urandom_range(0, 2) != 0;
                ra1 = AW'($urandom);
            end
        end

        repeat (LAT + 4) step(0, '0, 0, '0, 0);
        chk("drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
